// File: rtl/demux_1to2_hex_buffered.sv
// Registered 1-to-2 word distributor: each accepted input word goes to channel 0 or 1
// per in_sel, through a one-entry skid-free buffer per channel, with per-channel accept counters.
module demux_1to2_hex_buffered #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  buf_state_t state0;
  buf_state_t state1;
  logic       accept;
  logic       load0;
  logic       load1;
  logic       drain0;
  logic       drain1;

  // Ready depends only on the selected channel, so a stalled channel never blocks the other.
  assign in_ready = in_sel ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready);
  assign accept   = in_valid & in_ready;
  assign load0    = accept & ~in_sel;
  assign load1    = accept &  in_sel;
  assign drain0   = out0_valid & out0_ready;
  assign drain1   = out1_valid & out1_ready;

  assign out0_valid = (state0 == FULL);
  assign out1_valid = (state1 == FULL);

  // Channel 0 buffer: a load wins over a drain so a full buffer sustains one word per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state0    <= EMPTY;
      out0_data <= '0;
    end else begin
      case (state0)
        EMPTY: begin
          if (load0) begin
            state0    <= FULL;
            out0_data <= in_data;
          end
        end
        FULL: begin
          if (load0) begin
            out0_data <= in_data;
          end else if (drain0) begin
            state0 <= EMPTY;
          end
        end
        default: state0 <= EMPTY;
      endcase
    end
  end

  // Channel 1 buffer, same behaviour as channel 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state1    <= EMPTY;
      out1_data <= '0;
    end else begin
      case (state1)
        EMPTY: begin
          if (load1) begin
            state1    <= FULL;
            out1_data <= in_data;
          end
        end
        FULL: begin
          if (load1) begin
            out1_data <= in_data;
          end else if (drain1) begin
            state1 <= EMPTY;
          end
        end
        default: state1 <= EMPTY;
      endcase
    end
  end

  // Accept counters; a clear takes priority over a same-cycle accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (cnt_clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (load0) cnt0 <= cnt0 + CNT_W'(1);
      if (load1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_1to2_hex_buffered.sv
// Bench for demux_1to2_hex_buffered: array-based channel model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_demux_1to2_hex_buffered;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [15:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic        cnt_clr;
  logic [7:0]  cnt0;
  logic [7:0]  cnt1;

  int passed = 0;
  int total  = 0;

  demux_1to2_hex_buffered #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Channel model: buffer contents per channel and accept counts.
  int m_valid [2];
  int m_data  [2];
  int m_cnt   [2];

  function automatic int exp_ready();
    int s;
    s = (in_sel === 1'b1) ? 1 : 0;
    return (m_valid[s] == 0 || (s == 0 ? out0_ready : out1_ready)) ? 1 : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        m_valid[n] = 0;
        m_data[n]  = 0;
        m_cnt[n]   = 0;
      end
    end else begin
      int s;
      int acc;
      s   = in_sel ? 1 : 0;
      acc = (in_valid && exp_ready() == 1) ? 1 : 0;
      if (m_valid[0] == 1 && out0_ready) m_valid[0] = 0;
      if (m_valid[1] == 1 && out1_ready) m_valid[1] = 0;
      if (acc == 1) begin
        m_valid[s] = 1;
        m_data[s]  = int'(in_data);
      end
      if (cnt_clr) begin
        m_cnt[0] = 0;
        m_cnt[1] = 0;
      end else if (acc == 1) begin
        m_cnt[s] = (m_cnt[s] + 1) % 256;
      end
    end
  end

  // Per-cycle comparison; inputs change just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    check("model_out0_valid", 32'(out0_valid), 32'(m_valid[0]));
    check("model_out1_valid", 32'(out1_valid), 32'(m_valid[1]));
    check("model_out0_data",  32'(out0_data),  32'(m_data[0]));
    check("model_out1_data",  32'(out1_data),  32'(m_data[1]));
    check("model_cnt0",       32'(cnt0),       32'(m_cnt[0]));
    check("model_cnt1",       32'(cnt1),       32'(m_cnt[1]));
    check("model_in_ready",   32'(in_ready),   32'(exp_ready()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    check("reset_out0_valid", 32'(out0_valid), 32'd0);
    check("reset_cnt0", 32'(cnt0), 32'd0);

    // Routing
    drive(1'b1, 1'b0, 16'h1234, 1'b1, 1'b1);
    tick();
    check("route_out0_data", 32'(out0_data), 32'h1234);
    check("route_out0_valid", 32'(out0_valid), 32'd1);
    drive(1'b1, 1'b1, 16'hABCD, 1'b1, 1'b1);
    tick();
    check("route_out1_data", 32'(out1_data), 32'hABCD);
    check("route_cnt0", 32'(cnt0), 32'd1);
    check("route_cnt1", 32'(cnt1), 32'd1);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();

    // Backpressure on channel 0
    drive(1'b1, 1'b0, 16'h0001, 1'b0, 1'b1);
    tick();
    check("bp_first_loaded", 32'(out0_data), 32'h0001);
    in_data = 16'h0002;
    #1;
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    tick();
    check("bp_hold_data", 32'(out0_data), 32'h0001);
    check("bp_hold_valid", 32'(out0_valid), 32'd1);
    out0_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_replace_data", 32'(out0_data), 32'h0002);
    check("bp_replace_valid", 32'(out0_valid), 32'd1);

    // Independence: ch0 stalled full, ch1 still accepts
    drive(1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0);
    #1;
    check("indep_ready", 32'(in_ready), 32'd1);
    tick();
    check("indep_out1_valid", 32'(out1_valid), 32'd1);
    check("indep_out1_data", 32'(out1_data), 32'h00FF);
    check("indep_out0_held", 32'(out0_data), 32'h0002);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();
    check("drain_out0_valid", 32'(out0_valid), 32'd0);

    // Throughput: back-to-back words to ch1
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 16'h5000 + 16'(i), 1'b1, 1'b1);
      #1;
      check("tput_ready", 32'(in_ready), 32'd1);
      tick();
      check("tput_data", 32'(out1_data), 32'h5000 + 32'(i));
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();

    // Counter clear, wrap, and clear-over-accept
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt0", 32'(cnt0), 32'd0);
    check("clr_cnt1", 32'(cnt1), 32'd0);
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 16'(i), 1'b1, 1'b1);
      tick();
      if (i == 254) check("wrap_cnt0_255", 32'(cnt0), 32'd255);
    end
    check("wrap_cnt0_0", 32'(cnt0), 32'd0);
    tick();
    check("wrap_cnt0_1", 32'(cnt0), 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_wins_cnt0", 32'(cnt0), 32'd0);
    check("clr_wins_loaded", 32'(out0_data), 32'h00FF);

    // Reset mid-run with both buffers full
    drive(1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 16'hCAFE, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("full_out0_valid", 32'(out0_valid), 32'd1);
    check("full_out1_valid", 32'(out1_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_out0_valid", 32'(out0_valid), 32'd0);
    check("async_out1_valid", 32'(out1_valid), 32'd0);
    check("async_out0_data", 32'(out0_data), 32'd0);
    check("async_out1_data", 32'(out1_data), 32'd0);
    check("async_cnt0", 32'(cnt0), 32'd0);
    check("async_cnt1", 32'(cnt1), 32'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
